// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: opcode and state encodings shared by the shift sequencer and its single-step shifter.
package shift_sequencer_pkg;
   localparam logic [2:0] OP_ASL = 3'b000;
   localparam logic [2:0] OP_ASR = 3'b001;
   localparam logic [2:0] OP_LSL = 3'b010;
   localparam logic [2:0] OP_LSR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;
   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: combinational one-bit shift/rotate by opcode, with carry-out and arithmetic-left sign-change flag.
module shift_step
   import shift_sequencer_pkg::*;
#(
   parameter int NBITS = 4
) (
   input  logic [NBITS-1:0] x,
   input  logic [2:0]       op,
   output logic [NBITS-1:0] y,
   output logic             c,
   output logic             v
);
   always_comb begin
      y = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_ASL: begin
            y = {x[NBITS-2:0], 1'b0};
            c = x[NBITS-1];
            v = x[NBITS-1] ^ x[NBITS-2];
         end
         OP_ASR: begin
            y = {x[NBITS-1], x[NBITS-1:1]};
            c = x[0];
         end
         OP_LSL: begin
            y = {x[NBITS-2:0], 1'b0};
            c = x[NBITS-1];
         end
         OP_LSR: begin
            y = {1'b0, x[NBITS-1:1]};
            c = x[0];
         end
         OP_ROL: begin
            y = {x[NBITS-2:0], x[NBITS-1]};
            c = x[NBITS-1];
         end
         OP_ROR: begin
            y = {x[0], x[NBITS-1:1]};
            c = x[0];
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-position shift/rotate applying one single-bit step per clock, with start/done handshake.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int NBITS = 4,
   parameter int CW    = 3
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [NBITS-1:0] DIN,
   input  logic [2:0]       OPCODE,
   input  logic [CW-1:0]    COUNT,
   output logic             BUSY,
   output logic             DONE,
   output logic [NBITS-1:0] DOUT,
   output logic             CARRY,
   output logic             OVF
);
   state_t           state;
   logic [2:0]       opReg;
   logic [CW-1:0]    stepCount;
   logic [NBITS-1:0] stepResult;
   logic             stepCarry;
   logic             stepOvf;

   shift_step #(.NBITS(NBITS)) u_step (
      .x  (DOUT),
      .op (opReg),
      .y  (stepResult),
      .c  (stepCarry),
      .v  (stepOvf)
   );

   // BUSY and DONE are registered copies of "next state is SHIFT/FIN"
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         opReg     <= '0;
         stepCount <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         DOUT      <= '0;
         CARRY     <= 1'b0;
         OVF       <= 1'b0;
      end else if (state == SHIFT) begin
         DOUT      <= stepResult;
         CARRY     <= stepCarry;
         OVF       <= OVF | stepOvf;
         stepCount <= stepCount - 1'b1;
         if (stepCount == CW'(1)) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
         end
      end else if (START) begin
         DOUT      <= DIN;
         opReg     <= OPCODE;
         stepCount <= COUNT;
         CARRY     <= 1'b0;
         OVF       <= 1'b0;
         state     <= (COUNT != '0) ? SHIFT : FIN;
         BUSY      <= (COUNT != '0);
         DONE      <= (COUNT == '0);
      end else begin
         state <= IDLE;
         DONE  <= 1'b0;
      end
   end
endmodule
